add8_err_sweep_ctrl: RTL and testbench
======================================

// Module: add8_err_sweep_ctrl
// PURPOSE
//  Sequencer that characterises one approximate WIDTH-bit adder instance by exhaustive sweep.
//  Drives every operand pair into the external adder under test and compares each result against the exact sum.
//  Accumulates sum of absolute error, error count and worst-case error (WCE), plus the first pair reaching WCE.
//  Sits beside an add8_* netlist on the characterisation bench / FPGA error monitor.
// PARAMETERS
//  WIDTH  8  operand width of adder under test; sweep length 2^(2*WIDTH)
//  LAT    0  cycles from dut_a/dut_b registered change to dut_o valid (0..4)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          synchronous active-high reset
//  start      in   1          begin a sweep; honoured only when busy=0
//  dut_a      out  WIDTH      operand A to adder under test (registered)
//  dut_b      out  WIDTH      operand B to adder under test (registered)
//  dut_o      in   WIDTH+1    result from adder under test
//  busy       out  1          sweep in progress
//  done       out  1          one-cycle pulse when statistics are final
//  sae        out  3*WIDTH+1  sum of |dut_o - (a+b)| over the sweep
//  err_cnt    out  2*WIDTH+1  number of pairs with nonzero error
//  wce        out  WIDTH+1    maximum |error|
//  wce_a      out  WIDTH      A of first pair reaching wce
//  wce_b      out  WIDTH      B of first pair reaching wce
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE. Reset mid-sweep aborts; no done pulse; stats cleared.
//  FSM: IDLE -(start)-> SWEEP -(last pair issued)-> DRAIN -(LAT+1 compares done)-> FIN -> IDLE.
//  Start accepted in IDLE: next cycle busy=1, stats cleared to 0, dut_a=0, dut_b=0.
//  SWEEP: one pair per cycle, index {dut_a,dut_b} increments by 1 (b inner, a outer).
//   After {all-ones,all-ones}, operands hold and FSM enters DRAIN.
//  Compare pipeline: operand copy delayed LAT cycles; at LAT=0, compare in the same cycle dut_a/dut_b are presented.
//   Each pair is compared exactly once. Total compares = 2^(2*WIDTH).
//  Error: exact = a+b (WIDTH+1 bits, no overflow); err = |dut_o - exact| computed in WIDTH+2 signed,
//   magnitude WIDTH+1 bits.
//  Update per compare, registered: sae += err; err_cnt += (err!=0);
//   if err > wce: wce=err, wce_a/b=pair. Strictly greater, so the first pair in sweep order wins ties.
//  Widths sized so no accumulator can overflow; no saturation logic.
//  FIN: done=1 for one cycle, busy drops with it; stats hold until next accepted start or rst.
//  start while busy=1 is ignored (no restart, no stat change). start in the FIN cycle is ignored.
//  Back-to-back sweeps: start in the cycle after done begins a new sweep and clears stats.
//  busy length = 2^(2*WIDTH) + LAT + 1 cycles (SWEEP + DRAIN + FIN).
// TESTING
//  1. Exact adder model (LAT=0), start -> done after 65537 busy cycles; sae=0, err_cnt=0, wce=0, wce_a=wce_b=0.
//  2. Model o=(a+b)&~1 -> err_cnt=32768, sae=32768, wce=1, wce_a=0, wce_b=1.
//  3. Model o=0 -> sae=16711680, err_cnt=65535, wce=510, wce_a=255, wce_b=255.
//  4. LAT=2 with exact adder behind a 2-stage register -> all stats 0.
//     Same DUT with LAT=0 -> err_cnt>0.
//  5. start pulsed at cycle 100 of a sweep -> ignored; final stats identical to test 2; single done pulse.
//  6. rst at cycle 1000 of a sweep -> next cycle busy=0, all stats 0, no done.
//     Fresh start then gives test-2 results.

Source files
------------

// File: rtl/add8_err_sweep_ctrl.sv
// Purpose: exhaustively sweeps an external WIDTH-bit approximate adder and accumulates SAE, error count and WCE.
// Latency: one operand pair per cycle; adder result expected LAT cycles after operands; stats final on the done pulse.
// Backpressure: none; start is ignored while busy, and the adder under test must keep pace at one pair per cycle.
module add8_err_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int LAT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  input  logic [WIDTH:0]     dut_o,
  output logic               busy,
  output logic               done,
  output logic [3*WIDTH:0]   sae,
  output logic [2*WIDTH:0]   err_cnt,
  output logic [WIDTH:0]     wce,
  output logic [WIDTH-1:0]   wce_a,
  output logic [WIDTH-1:0]   wce_b
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, FIN} state_t;

  // Last drain cycle index; unused when LAT=0 because SWEEP goes straight to FIN.
  localparam logic [2:0] DRAIN_LAST = 3'(LAT - 1);

  state_t              state_q, state_d;
  logic [2*WIDTH-1:0]  idx_q;
  logic [2:0]          drain_cnt;
  logic                start_acc;
  logic                last_pair;

  logic                cmp_vld;
  logic [WIDTH-1:0]    cmp_a, cmp_b;
  logic [WIDTH:0]      exact;
  logic [WIDTH+1:0]    diff, diff_neg;
  logic [WIDTH:0]      err_mag;

  // Operands come straight from the sweep index register: a is the outer loop, b the inner.
  assign dut_a     = idx_q[2*WIDTH-1:WIDTH];
  assign dut_b     = idx_q[WIDTH-1:0];
  assign last_pair = (idx_q == {(2*WIDTH){1'b1}});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and status outputs; start is only honoured from IDLE.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SWEEP;
          start_acc = 1'b1;
        end
      end
      SWEEP: begin
        if (last_pair) state_d = (LAT == 0) ? FIN : DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep index: cleared on an accepted start, steps once per SWEEP cycle, holds on the last pair.
  always_ff @(posedge clk) begin
    if (rst)                                idx_q <= '0;
    else if (start_acc)                     idx_q <= '0;
    else if (state_q == SWEEP && !last_pair) idx_q <= idx_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
  end

  // Drain counter: number of cycles spent waiting for the adder pipeline to empty.
  always_ff @(posedge clk) begin
    if (rst)                    drain_cnt <= 3'd0;
    else if (state_q == DRAIN)  drain_cnt <= drain_cnt + 3'd1;
    else                        drain_cnt <= 3'd0;
  end

  // Delay the issued pair by LAT cycles so it lines up with the adder result it produced.
  generate
    if (LAT == 0) begin : g_nodelay
      assign cmp_vld = (state_q == SWEEP);
      assign cmp_a   = dut_a;
      assign cmp_b   = dut_b;
    end else begin : g_delay
      logic             vld_pipe [LAT];
      logic [WIDTH-1:0] a_pipe   [LAT];
      logic [WIDTH-1:0] b_pipe   [LAT];

      // Valid tags are reset so an aborted sweep leaves nothing in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) vld_pipe[i] <= 1'b0;
        end else begin
          vld_pipe[0] <= (state_q == SWEEP);
          for (int i = 1; i < LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end

      // Operand copies travel alongside the valid tags.
      always_ff @(posedge clk) begin
        a_pipe[0] <= dut_a;
        b_pipe[0] <= dut_b;
        for (int i = 1; i < LAT; i++) begin
          a_pipe[i] <= a_pipe[i-1];
          b_pipe[i] <= b_pipe[i-1];
        end
      end

      assign cmp_vld = vld_pipe[LAT-1];
      assign cmp_a   = a_pipe[LAT-1];
      assign cmp_b   = b_pipe[LAT-1];
    end
  endgenerate

  // Absolute error: difference taken one bit wider than the sum so the sign is never lost.
  always_comb begin
    exact    = {1'b0, cmp_a} + {1'b0, cmp_b};
    diff     = {1'b0, dut_o} - {1'b0, exact};
    diff_neg = '0 - diff;
    err_mag  = diff[WIDTH+1] ? diff_neg[WIDTH:0] : diff[WIDTH:0];
  end

  // Statistics: cleared on start, updated once per compare; strict > keeps the first pair on WCE ties.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      sae     <= '0;
      err_cnt <= '0;
      wce     <= '0;
      wce_a   <= '0;
      wce_b   <= '0;
    end else if (cmp_vld) begin
      sae <= sae + {{(2*WIDTH){1'b0}}, err_mag};
      if (err_mag != '0) err_cnt <= err_cnt + {{(2*WIDTH){1'b0}}, 1'b1};
      if (err_mag > wce) begin
        wce   <= err_mag;
        wce_a <= cmp_a;
        wce_b <= cmp_b;
      end
    end
  end

endmodule

// File: tb/tb_add8_err_sweep_ctrl.sv
// Purpose: checks the sweep controller at WIDTH=4 (LAT 0 and 2) and WIDTH=8 against a loop-based reference.
// Latency: expected statistics are queued at start and compared on each done pulse, with busy length.
// Backpressure: not applicable; a timed-out sweep is reported and the run still reaches its summary.
module tb_add8_err_sweep_ctrl;

  typedef struct {
    longint sae, cnt, wce, wa, wb, blen;
    bit     nz;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // u0: WIDTH=4 LAT=0, u2: WIDTH=4 LAT=2, u8: WIDTH=8 LAT=0
  logic rst0 = 1'b1, rst2 = 1'b1, rst8 = 1'b1;
  logic start0 = 1'b0, start2 = 1'b0, start8 = 1'b0;
  logic [3:0]  a0, b0, a2, b2, wa0, wb0, wa2, wb2;
  logic [4:0]  o0, o2, wce0, wce2;
  logic [12:0] sae0, sae2;
  logic [8:0]  cnt0, cnt2;
  logic [7:0]  a8, b8, wa8, wb8;
  logic [8:0]  o8, wce8;
  logic [24:0] sae8;
  logic [16:0] cnt8;
  logic busy0, busy2, busy8, done0, done2, done8;

  int mode0 = 0, mode2 = 0, mode8 = 2;
  bit del0 = 1'b0;
  int tab0 [256];
  int tab2 [256];
  exp_t q0[$], q2[$], q8[$];
  exp_t last0;

  add8_err_sweep_ctrl #(.WIDTH(4), .LAT(0)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .dut_a(a0), .dut_b(b0), .dut_o(o0),
    .busy(busy0), .done(done0), .sae(sae0), .err_cnt(cnt0), .wce(wce0), .wce_a(wa0), .wce_b(wb0));
  add8_err_sweep_ctrl #(.WIDTH(4), .LAT(2)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .dut_a(a2), .dut_b(b2), .dut_o(o2),
    .busy(busy2), .done(done2), .sae(sae2), .err_cnt(cnt2), .wce(wce2), .wce_a(wa2), .wce_b(wb2));
  add8_err_sweep_ctrl #(.WIDTH(8), .LAT(0)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .dut_a(a8), .dut_b(b8), .dut_o(o8),
    .busy(busy8), .done(done8), .sae(sae8), .err_cnt(cnt8), .wce(wce8), .wce_a(wa8), .wce_b(wb8));

  // Adder-under-test behaviours: 0 exact, 1 LSB cleared, 2 constant zero, 3 exact plus a random error table.
  function automatic int adder_f(int mode, int a, int b, int w, int sel);
    int s = a + b;
    int t;
    case (mode)
      0: return s;
      1: return s & ~1;
      2: return 0;
      default: begin
        t = (sel == 0) ? tab0[a*16+b] : tab2[a*16+b];
        return (s + t) & ((1 << (w + 1)) - 1);
      end
    endcase
  endfunction

  // Reference: walk every pair in sweep order and accumulate the statistics directly.
  function automatic exp_t model(int w, int mode, int sel, int lat);
    exp_t e;
    int o, d;
    e.sae = 0; e.cnt = 0; e.wce = 0; e.wa = 0; e.wb = 0; e.nz = 1'b0;
    for (int a = 0; a < (1 << w); a++) begin
      for (int b = 0; b < (1 << w); b++) begin
        o = adder_f(mode, a, b, w, sel);
        d = o - (a + b);
        if (d < 0) d = -d;
        e.sae += d;
        if (d != 0) e.cnt++;
        if (d > e.wce) begin e.wce = d; e.wa = a; e.wb = b; end
      end
    end
    e.blen = (1 << (2 * w)) + lat + 1;
    return e;
  endfunction

  // Emulated adders: u0/u8 combinational (settled by mid-cycle), u2 behind two registers.
  int f0_now, f8_now, q0_1, q0_2, d2_1, d2_2;
  always @(negedge clk) begin
    f0_now <= adder_f(mode0, int'(a0), int'(b0), 4, 0);
    f8_now <= adder_f(mode8, int'(a8), int'(b8), 8, 0);
  end
  always @(posedge clk) begin
    q0_1 <= adder_f(mode0, int'(a0), int'(b0), 4, 0);
    q0_2 <= q0_1;
    d2_1 <= adder_f(mode2, int'(a2), int'(b2), 4, 1);
    d2_2 <= d2_1;
  end
  assign o0 = del0 ? q0_2[4:0] : f0_now[4:0];
  assign o2 = d2_2[4:0];
  assign o8 = f8_now[8:0];

  task automatic check(string nm, longint act, longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic cmp_stats(string tag, exp_t e, longint sae, longint cnt, longint wce,
                           longint wa, longint wb, longint blen);
    if (e.nz) begin
      check({tag, "_err_cnt_nonzero"}, longint'(cnt != 0), 1);
    end else begin
      check({tag, "_sae"}, sae, e.sae);
      check({tag, "_err_cnt"}, cnt, e.cnt);
      check({tag, "_wce"}, wce, e.wce);
      check({tag, "_wce_a"}, wa, e.wa);
      check({tag, "_wce_b"}, wb, e.wb);
    end
    check({tag, "_busy_len"}, blen, e.blen);
  endtask

  task automatic chk_zero(string tag, longint busy, longint done, longint sae, longint cnt,
                          longint wce, longint wa, longint wb, longint a, longint b);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sae"}, sae, 0);
    check({tag, "_err_cnt"}, cnt, 0);
    check({tag, "_wce"}, wce, 0);
    check({tag, "_wce_ab"}, wa + wb, 0);
    check({tag, "_dut_ab"}, a + b, 0);
  endtask

  // Monitors: pop one expectation per done pulse; a done with nothing queued is an extra pulse.
  initial begin : mon0
    exp_t e;
    longint bl = 0;
    forever begin
      @(negedge clk);
      if (busy0) bl++;
      if (done0) begin
        check("u0_done_expected", longint'(q0.size() != 0), 1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          cmp_stats("u0", e, sae0, cnt0, wce0, wa0, wb0, bl);
        end
      end
      if (!busy0) bl = 0;
    end
  end

  initial begin : mon2
    exp_t e;
    longint bl = 0;
    forever begin
      @(negedge clk);
      if (busy2) bl++;
      if (done2) begin
        check("u2_done_expected", longint'(q2.size() != 0), 1);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          cmp_stats("u2", e, sae2, cnt2, wce2, wa2, wb2, bl);
        end
      end
      if (!busy2) bl = 0;
    end
  end

  initial begin : mon8
    exp_t e;
    longint bl = 0;
    forever begin
      @(negedge clk);
      if (busy8) bl++;
      if (done8) begin
        check("u8_done_expected", longint'(q8.size() != 0), 1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          cmp_stats("u8", e, sae8, cnt8, wce8, wa8, wb8, bl);
        end
      end
      if (!busy8) bl = 0;
    end
  end

  function automatic int qsize(int sel);
    case (sel)
      0: return q0.size();
      2: return q2.size();
      default: return q8.size();
    endcase
  endfunction

  task automatic fill(int sel);
    int e;
    for (int i = 0; i < 256; i++) begin
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) - 8 : 0;
      if (sel == 0) tab0[i] = e;
      else          tab2[i] = e;
    end
  endtask

  task automatic set_start(int sel, logic v);
    case (sel)
      0: start0 = v;
      2: start2 = v;
      default: start8 = v;
    endcase
  endtask

  // Queue the expectation, then pulse start for one cycle.
  task automatic go(int sel, int mode, bit nz);
    exp_t e;
    case (sel)
      0: begin mode0 = mode; e = model(4, mode, 0, 0); end
      2: begin mode2 = mode; e = model(4, mode, 1, 2); end
      default: begin mode8 = mode; e = model(8, mode, 0, 0); end
    endcase
    e.nz = nz;
    @(negedge clk);
    case (sel)
      0: begin q0.push_back(e); last0 = e; end
      2: q2.push_back(e);
      default: q8.push_back(e);
    endcase
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
  endtask

  task automatic junk(int sel, int cyc);
    repeat (cyc) @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
  endtask

  task automatic wait_done(int sel, int budget);
    int c = 0;
    while (qsize(sel) != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (qsize(sel) != 0) begin
      check($sformatf("u%0d_done_timeout", sel), longint'(qsize(sel)), 0);
      case (sel)
        0: q0.delete();
        2: q2.delete();
        default: q8.delete();
      endcase
    end
    @(negedge clk);
  endtask

  initial begin : main
    int c;
    exp_t e;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst2 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    chk_zero("u0_reset", busy0, done0, sae0, cnt0, wce0, wa0, wb0, a0, b0);
    chk_zero("u2_reset", busy2, done2, sae2, cnt2, wce2, wa2, wb2, a2, b2);
    chk_zero("u8_reset", busy8, done8, sae8, cnt8, wce8, wa8, wb8, a8, b8);

    fork
      begin : seq0
        for (int i = 0; i < 8; i++) begin
          if (i >= 3) fill(0);
          go(0, (i < 3) ? i : 3, 1'b0);
          junk(0, (i == 1) ? 100 : int'($urandom_range(10, 240)));
          wait_done(0, 2000);
          @(negedge clk);
          check("u0_hold_sae", sae0, last0.sae);
          check("u0_hold_wce", wce0, last0.wce);
        end
        // Abort mid-sweep: stats and busy clear, no done pulse, then a clean rerun.
        go(0, 1, 1'b0);
        repeat (100) @(negedge clk);
        void'(q0.pop_back());
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk_zero("u0_abort", busy0, done0, sae0, cnt0, wce0, wa0, wb0, a0, b0);
        repeat (5) @(negedge clk);
        go(0, 1, 1'b0);
        wait_done(0, 2000);
        // Start held through FIN (ignored) and the following IDLE cycle (accepted).
        go(0, 1, 1'b0);
        c = 0;
        while (!done0 && c < 2000) begin
          @(negedge clk);
          c++;
        end
        if (!done0) check("u0_fin_timeout", longint'(done0), 1);
        mode0 = 2;
        e = model(4, 2, 0, 0);
        e.nz = 1'b0;
        q0.push_back(e);
        start0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 2000);
        // Adder with two cycles of latency compared as if it had none.
        del0 = 1'b1;
        go(0, 0, 1'b1);
        wait_done(0, 2000);
        del0 = 1'b0;
      end
      begin : seq2
        for (int i = 0; i < 6; i++) begin
          if ((i % 4) == 3) fill(1);
          go(2, i % 4, 1'b0);
          junk(2, int'($urandom_range(10, 240)));
          wait_done(2, 2000);
        end
      end
      begin : seq8
        go(8, 2, 1'b0);
        wait_done(8, 70000);
      end
    join

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
